// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates fetch reads and loader writes onto a single-port instruction memory.
// Optional feature: define IMEM_ARB_WRCOUNT_EN to build the saturating loader write counter on wr_count.
module imem_arbiter #(
    parameter int PC_WIDTH     = 16,
    parameter int INSTR_WIDTH  = 32,
    parameter int MAX_LOAD_RUN = 4
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   f_req,
    input  logic [PC_WIDTH-1:0]    f_addr,
    output logic                   f_gnt,
    output logic                   f_valid,
    output logic [INSTR_WIDTH-1:0] f_data,
    input  logic                   l_req,
    input  logic [PC_WIDTH-1:0]    l_addr,
    input  logic [INSTR_WIDTH-1:0] l_data,
    output logic                   l_gnt,
    output logic [PC_WIDTH-1:0]    m_addr,
    output logic                   m_we,
    output logic [INSTR_WIDTH-1:0] m_din,
    input  logic [INSTR_WIDTH-1:0] m_dout,
    output logic                   hold,
    output logic [15:0]            wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [3:0] RUN_LIMIT = 4'(MAX_LOAD_RUN);

    state_t                state_r;
    state_t                state_next_s;
    logic [3:0]            load_run_r;
    logic [3:0]            load_run_next_s;
    logic [PC_WIDTH-1:0]   m_addr_r;
    logic                  f_gnt_s;
    logic                  l_gnt_s;

    // Grant selection, next state and memory-port steering; reset masks every grant
    always_comb begin
        f_gnt_s      = 1'b0;
        l_gnt_s      = 1'b0;
        state_next_s = IDLE;
        m_addr       = m_addr_r;
        m_we         = 1'b0;
        m_din        = '0;
        if (!RST) begin
            state_next_s = IDLE;
        end else if (l_req && !(f_req && (load_run_r == RUN_LIMIT))) begin
            l_gnt_s      = 1'b1;
            state_next_s = LOAD;
            m_addr       = l_addr;
            m_we         = 1'b1;
            m_din        = l_data;
        end else if (f_req) begin
            f_gnt_s      = 1'b1;
            state_next_s = FETCH;
            m_addr       = f_addr;
        end else begin
            state_next_s = IDLE;
        end
    end

    // Count loader grants that starve a waiting fetch; any fetch grant or idle fetch side clears it
    always_comb begin
        load_run_next_s = load_run_r;
        if (!RST || f_gnt_s || !f_req) begin
            load_run_next_s = 4'd0;
        end else if (l_gnt_s && (load_run_r < RUN_LIMIT)) begin
            load_run_next_s = load_run_r + 4'd1;
        end else begin
            load_run_next_s = load_run_r;
        end
    end

    // State, run counter and held memory address
    always_ff @(posedge clk_in) begin
        if (!RST) begin
            state_r    <= IDLE;
            load_run_r <= 4'd0;
            m_addr_r   <= '0;
        end else begin
            state_r    <= state_next_s;
            load_run_r <= load_run_next_s;
            m_addr_r   <= m_addr;
        end
    end

    // Read data arrives one cycle after a fetch grant, which is exactly the FETCH state
    assign f_valid = (state_r == FETCH);
    assign f_data  = f_valid ? m_dout : '0;
    assign f_gnt   = f_gnt_s;
    assign l_gnt   = l_gnt_s;
    assign hold    = RST & f_req & ~f_gnt_s;

`ifdef IMEM_ARB_WRCOUNT_EN
    logic [15:0] wr_count_r;

    // Saturating count of accepted loader writes
    always_ff @(posedge clk_in) begin
        if (!RST) begin
            wr_count_r <= 16'd0;
        end else if (l_gnt_s && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'd1;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    assign wr_count = wr_count_r;
`else
    assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed stimulus with a per-cycle behavioural model of imem_arbiter.
module tb_imem_arbiter;
    localparam int PW  = 16;
    localparam int IW  = 32;
    localparam int MLR = 4;

    logic          clk_in = 1'b0;
    logic          RST;
    logic          f_req;
    logic [PW-1:0] f_addr;
    logic          f_gnt;
    logic          f_valid;
    logic [IW-1:0] f_data;
    logic          l_req;
    logic [PW-1:0] l_addr;
    logic [IW-1:0] l_data;
    logic          l_gnt;
    logic [PW-1:0] m_addr;
    logic          m_we;
    logic [IW-1:0] m_din;
    logic [IW-1:0] m_dout;
    logic          hold;
    logic [15:0]   wr_count;

    int   n_pass  = 0;
    int   n_total = 0;
    logic chk_en  = 1'b0;

    always #5 clk_in = ~clk_in;

    imem_arbiter #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .MAX_LOAD_RUN(MLR)) dut (
        .clk_in(clk_in), .RST(RST),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
        .l_req(l_req), .l_addr(l_addr), .l_data(l_data), .l_gnt(l_gnt),
        .m_addr(m_addr), .m_we(m_we), .m_din(m_din), .m_dout(m_dout),
        .hold(hold), .wr_count(wr_count)
    );

    // Environment memory: registered read, preloaded with one known word
    logic [IW-1:0] mem [0:255] = '{5: 32'hDEADBEEF, default: 32'h0};
    always @(posedge clk_in) begin
        if (m_we === 1'b1) mem[m_addr[7:0]] <= m_din;
        m_dout <= mem[m_addr[7:0]];
    end

    // Behavioural model: loader wins unless fetch has waited through MLR loader grants
    logic [IW-1:0] mm [0:255] = '{5: 32'hDEADBEEF, default: 32'h0};
    int            streak   = 0;
    int            exp_wr   = 0;
    logic          exp_pf   = 1'b0;
    logic [PW-1:0] exp_last = '0;
    logic [IW-1:0] exp_fd   = '0;
    logic          e_f;
    logic          e_l;

    always_comb begin
        e_f = 1'b0;
        e_l = 1'b0;
        if (RST === 1'b1) begin
            if (l_req && !(f_req && (streak >= MLR))) e_l = 1'b1;
            else if (f_req) e_f = 1'b1;
        end
    end

    always @(posedge clk_in) begin
        if (RST !== 1'b1) begin
            streak   <= 0;
            exp_pf   <= 1'b0;
            exp_last <= '0;
            exp_wr   <= 0;
        end else begin
            exp_pf <= e_f;
            if (e_f) begin
                exp_last <= f_addr;
                exp_fd   <= mm[f_addr[7:0]];
                streak   <= 0;
            end else if (e_l) begin
                exp_last        <= l_addr;
                mm[l_addr[7:0]] <= l_data;
                if (exp_wr < 65535) exp_wr <= exp_wr + 1;
                streak <= f_req ? ((streak < MLR) ? streak + 1 : streak) : 0;
            end else begin
                streak <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    logic [15:0] exp_wc;
    always_comb begin
        exp_wc = 16'd0;
`ifdef IMEM_ARB_WRCOUNT_EN
        exp_wc = 16'(exp_wr);
`endif
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("m_f_gnt",   64'(f_gnt),   64'(e_f));
            chk("m_l_gnt",   64'(l_gnt),   64'(e_l));
            chk("m_hold",    64'(hold),    64'(RST & f_req & ~e_f));
            chk("m_we",      64'(m_we),    64'(e_l));
            chk("m_din",     64'(m_din),   64'(e_l ? l_data : 32'h0));
            chk("m_addr",    64'(m_addr),  64'(e_f ? f_addr : (e_l ? l_addr : exp_last)));
            chk("m_f_valid", 64'(f_valid), 64'(exp_pf));
            chk("m_f_data",  64'(f_data),  64'(exp_pf ? exp_fd : 32'h0));
            chk("m_wr_count", 64'(wr_count), 64'(exp_wc));
        end
    end

    task automatic drive(input logic rst, input logic fr, input logic [PW-1:0] fa,
                         input logic lr, input logic [PW-1:0] la, input logic [IW-1:0] ld);
        RST = rst; f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_data = ld;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    logic [9:0]  gbits;
    logic [11:0] fp;
    logic [11:0] lp;
    int          hcnt;

    initial begin
        gbits = '0;
        hcnt  = 0;
        fp    = 12'b1110_1111_1100;
        lp    = 12'b1111_1111_0110;
        // Reset held low for three cycles with both requests asserted
        drive(1'b0, 1'b1, 16'h0007, 1'b1, 16'h0009, 32'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_en = 1'b1;
            @(negedge clk_in);
            chk("rst_f_gnt",   64'(f_gnt),   64'd0);
            chk("rst_l_gnt",   64'(l_gnt),   64'd0);
            chk("rst_m_we",    64'(m_we),    64'd0);
            chk("rst_f_valid", 64'(f_valid), 64'd0);
        end

        // Single fetch of a preloaded word
        tick(); drive(1'b1, 1'b1, 16'h0005, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("fetch_gnt",  64'(f_gnt),  64'd1);
        chk("fetch_addr", 64'(m_addr), 64'h5);
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("fetch_valid", 64'(f_valid), 64'd1);
        chk("fetch_data",  64'(f_data),  64'hDEADBEEF);

        // Loader write then fetch of the same address
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0010, 32'h12345678);
        @(negedge clk_in);
        chk("load_we",  64'(m_we),  64'd1);
        chk("load_din", 64'(m_din), 64'h12345678);
        tick(); drive(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("rdbk_gnt", 64'(f_gnt), 64'd1);
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("rdbk_data", 64'(f_data), 64'h12345678);

        // Contention: both requesters held for ten cycles
        for (int i = 0; i < 10; i++) begin
            tick(); drive(1'b1, 1'b1, 16'h0010, 1'b1, 16'(16'h20 + i), 32'hC0DE0000 + 32'(i));
            @(negedge clk_in);
            gbits = {gbits[8:0], f_gnt};
            if (l_gnt && hold) hcnt++;
        end
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("arb_pattern", 64'(gbits),  64'(10'b0000100001));
        chk("hold_cycles", 64'(hcnt),   64'd8);
        chk("idle_m_addr", 64'(m_addr), 64'h10);

        // Mixed request table, checked by the model
        for (int i = 0; i < 12; i++) begin
            tick(); drive(1'b1, fp[11-i], 16'(16'h30 + i), lp[11-i], 16'(16'h50 + i), 32'hA5000000 + 32'(i));
        end

        // Burst of four writes with reset dropped after the second
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0040, 32'hB0);
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0041, 32'hB1);
        for (int i = 0; i < 2; i++) begin
            tick(); drive(1'b0, 1'b1, 16'h0007, 1'b1, 16'(16'h42 + i), 32'hB2 + 32'(i));
            @(negedge clk_in);
            chk("burst_rst_l_gnt", 64'(l_gnt), 64'd0);
            chk("burst_rst_m_we",  64'(m_we),  64'd0);
            chk("burst_rst_hold",  64'(hold),  64'd0);
        end
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("post_rst_valid", 64'(f_valid),  64'd0);
        chk("post_rst_wrcnt", 64'(wr_count), 64'd0);
        tick(); drive(1'b1, 1'b1, 16'h0042, 1'b0, 16'h0, 32'h0);
        tick(); drive(1'b1, 1'b1, 16'h0041, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("burst_w3_absent", 64'(f_data), 64'h0);
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
        chk("burst_w2_present", 64'(f_data), 64'hB1);

        // Long loader stream to saturate the write counter
        tick(); drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0080, 32'h77);
        repeat (70000) @(posedge clk_in);
        #1; drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        @(negedge clk_in);
`ifdef IMEM_ARB_WRCOUNT_EN
        chk("wr_count_sat", 64'(wr_count), 64'hFFFF);
`else
        chk("wr_count_off", 64'(wr_count), 64'h0);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
